uart_responder: RTL and testbench

- Target-side peer of the CPU's UART request interface: services `uartReadReq`/`uartReadAck`/`uartReadData` and `uartWriteReq`/`uartWriteData`/`uartWriteReady`.
- Serialises CPU write bytes onto `tx`.
- Deserialises `rx` into a small receive FIFO that read requests drain.
- Sits beside `PhysicalRAM` at CPU top level and in the CPU bench.

---
 rtl/uart_responder.sv | 318 +++++++++++++++++++++++++++++++
 tb/tb_uart_responder.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_responder.sv
`timescale 1ns/1ps
// uart_responder
// ---------------------------------------------------------------------------
// Target-side UART peer for the CPU request interface. CPU writes are
// serialised onto tx as 8N1 frames (LSB first). Frames arriving on rx are
// deserialised into a small circular receive FIFO that CPU read requests
// drain one byte at a time.
//
// Parameters
//   CLKS_PER_BIT : clock cycles per serial bit (>= 4)
//   FIFO_DEPTH   : receive FIFO entries (power of 2, >= 2)
//
// Ports
//   clk            : system clock, all logic on posedge
//   reset          : asynchronous, active-low reset
//   rx             : serial receive line, idle high, asynchronous to clk
//   tx             : serial transmit line, idle high
//   uartReadReq    : CPU level request for one received byte
//   uartReadAck    : one-cycle acknowledge, uartReadData valid with it
//   uartReadData   : received byte, holds its value between acks
//   uartWriteReq   : one-cycle write strobe, honoured while uartWriteReady
//   uartWriteData  : byte to send, sampled with uartWriteReq
//   uartWriteReady : transmitter idle and able to accept a byte
//   rxOverrun      : sticky, a received byte was dropped on a full FIFO
// ---------------------------------------------------------------------------
module uart_responder #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic       tx,
    input  logic       uartReadReq,
    output logic       uartReadAck,
    output logic [7:0] uartReadData,
    input  logic       uartWriteReq,
    input  logic [7:0] uartWriteData,
    output logic       uartWriteReady,
    output logic       rxOverrun
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int AW    = $clog2(FIFO_DEPTH);

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2);
    localparam logic [AW:0]      PTR_ONE  = {{AW{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    // -----------------------------------------------------------------------
    // rx synchroniser: idle-high reset value keeps the receiver from seeing
    // a phantom start bit as reset is released.
    // -----------------------------------------------------------------------
    logic rx_meta;
    logic rx_sync;

    // NOTE: sequential state is always updated with non-blocking assignments
    // so every flop samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
        end
    end

    // -----------------------------------------------------------------------
    // Receive FSM
    // -----------------------------------------------------------------------
    rx_state_t        rx_state_q, rx_state_d;
    logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]       rx_bit_q, rx_bit_d;
    logic [7:0]       rx_shift_q, rx_shift_d;
    logic             rx_done;     // good stop bit seen, rx_shift_q holds the byte

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
        end
    end

    // NOTE: every signal assigned in a combinational block gets a default
    // first, so no path through the case statement can infer a latch.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_done    = 1'b0;

        case (rx_state_q)
            RX_IDLE: begin
                if (!rx_sync) begin
                    rx_state_d = RX_START;
                    rx_cnt_d   = '0;
                end
            end

            RX_START: begin
                // Re-check half a bit in; a line back high means a glitch.
                if (rx_cnt_q == CNT_HALF) begin
                    if (rx_sync) begin
                        rx_state_d = RX_IDLE;
                    end else begin
                        rx_state_d = RX_DATA;
                        rx_cnt_d   = '0;
                        rx_bit_d   = '0;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_ONE;
                end
            end

            RX_DATA: begin
                // Counter is now aligned to mid-bit; shift right so bit 0,
                // which arrives first, ends up in the LSB.
                if (rx_cnt_q == CNT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_sync, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = RX_STOP;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_ONE;
                end
            end

            RX_STOP: begin
                // A low stop bit is a framing error: the byte is dropped
                // silently and does not count as an overrun.
                if (rx_cnt_q == CNT_LAST) begin
                    rx_state_d = RX_IDLE;
                    rx_cnt_d   = '0;
                    rx_done    = rx_sync;
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_ONE;
                end
            end

            default: begin
                rx_state_d = RX_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Receive FIFO and CPU read handshake
    // Pointers carry one extra wrap bit: equal pointers mean empty, equal
    // index with differing wrap bits means full.
    // -----------------------------------------------------------------------
    logic [7:0]  fifo_mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        fifo_empty;
    logic        fifo_full;
    logic        read_fire;
    logic        push_ok;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                        (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // The previous-cycle ack blocks a second pop while the CPU is still
    // dropping its request.
    assign read_fire = uartReadReq && !fifo_empty && !uartReadAck;

    // A pop in the same cycle frees the slot the push is about to use.
    assign push_ok = rx_done && (!fifo_full || read_fire);

    // NOTE: the FIFO storage has no reset; the pointers alone define which
    // entries are valid, so clearing the array would only cost logic.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr[AW-1:0]] <= rx_shift_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            uartReadAck  <= 1'b0;
            uartReadData <= '0;
            rxOverrun    <= 1'b0;
        end else begin
            uartReadAck <= read_fire;
            if (read_fire) begin
                uartReadData <= fifo_mem[rd_ptr[AW-1:0]];
                rd_ptr       <= rd_ptr + PTR_ONE;
            end
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rx_done && fifo_full && !read_fire) begin
                rxOverrun <= 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Transmit FSM
    // tx is registered so the line never glitches; the byte is shifted right
    // as each data bit completes so the next bit is always tx_shift_q[1].
    // -----------------------------------------------------------------------
    tx_state_t        tx_state_q, tx_state_d;
    logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]       tx_bit_q, tx_bit_d;
    logic [7:0]       tx_shift_q, tx_shift_d;
    logic             tx_q, tx_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_q       <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_q       <= tx_d;
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_d       = tx_q;

        case (tx_state_q)
            TX_IDLE: begin
                tx_d = 1'b1;
                if (uartWriteReq) begin
                    tx_state_d = TX_START;
                    tx_cnt_d   = '0;
                    tx_shift_d = uartWriteData;
                    tx_d       = 1'b0;
                end
            end

            TX_START: begin
                if (tx_cnt_q == CNT_LAST) begin
                    tx_state_d = TX_DATA;
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    tx_d       = tx_shift_q[0];
                end else begin
                    tx_cnt_d = tx_cnt_q + CNT_ONE;
                end
            end

            TX_DATA: begin
                if (tx_cnt_q == CNT_LAST) begin
                    tx_cnt_d = '0;
                    if (tx_bit_q == 3'd7) begin
                        tx_state_d = TX_STOP;
                        tx_d       = 1'b1;
                    end else begin
                        tx_bit_d   = tx_bit_q + 3'd1;
                        tx_shift_d = {1'b0, tx_shift_q[7:1]};
                        tx_d       = tx_shift_q[1];
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + CNT_ONE;
                end
            end

            TX_STOP: begin
                tx_d = 1'b1;
                if (tx_cnt_q == CNT_LAST) begin
                    tx_state_d = TX_IDLE;
                    tx_cnt_d   = '0;
                end else begin
                    tx_cnt_d = tx_cnt_q + CNT_ONE;
                end
            end

            default: begin
                tx_state_d = TX_IDLE;
                tx_d       = 1'b1;
            end
        endcase
    end

    assign tx             = tx_q;
    assign uartWriteReady = (tx_state_q == TX_IDLE);

endmodule

// File: tb/tb_uart_responder.sv
`timescale 1ns/1ps
// tb_uart_responder
// ---------------------------------------------------------------------------
// Self-checking bench for uart_responder with CLKS_PER_BIT = 4 and
// FIFO_DEPTH = 4. A behavioural model (frame bit list for tx, a byte queue
// for the receive FIFO, a fixed arrival latency for rx frames) predicts every
// output; a compare loop checks the DUT against it each negative clock edge.
// Directed scenarios add hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_uart_responder;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * CPB;
    // Edges from the edge after which the start bit is driven to the edge
    // that pushes the byte: 2 synchroniser flops, 1 to leave idle,
    // CPB/2+1 in start, 8*CPB data, CPB stop.
    localparam int RX_LAT = 2 + 1 + (CPB / 2 + 1) + 8 * CPB + CPB;

    logic       clk;
    logic       reset;
    logic       rx;
    logic       tx;
    logic       uartReadReq;
    logic       uartReadAck;
    logic [7:0] uartReadData;
    logic       uartWriteReq;
    logic [7:0] uartWriteData;
    logic       uartWriteReady;
    logic       rxOverrun;

    uart_responder #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .rx            (rx),
        .tx            (tx),
        .uartReadReq   (uartReadReq),
        .uartReadAck   (uartReadAck),
        .uartReadData  (uartReadData),
        .uartWriteReq  (uartWriteReq),
        .uartWriteData (uartWriteData),
        .uartWriteReady(uartWriteReady),
        .rxOverrun     (rxOverrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // -----------------------------------------------------------------------
    // Behavioural model
    // -----------------------------------------------------------------------
    typedef struct {
        int         due;
        logic [7:0] data;
        logic       stop;
    } frame_t;

    int         cyc = 0;
    int         m_tx_left = 0;
    logic [9:0] m_tx_frame = '1;
    logic [7:0] m_q[$];
    frame_t     pend[$];
    logic       m_ack = 1'b0;
    logic [7:0] m_data = '0;
    logic       m_ovr = 1'b0;

    function automatic logic m_tx_exp();
        logic [9:0] sh;
        if (m_tx_left == 0) return 1'b1;
        sh = m_tx_frame >> ((FRAME - m_tx_left) / CPB);
        return sh[0];
    endfunction

    initial forever begin
        @(posedge clk or negedge reset);
        if (!reset) begin
            m_tx_left = 0;
            m_q.delete();
            pend.delete();
            m_ack  = 1'b0;
            m_data = '0;
            m_ovr  = 1'b0;
        end else begin
            cyc++;
            if (m_tx_left > 0) begin
                m_tx_left--;
            end else if (uartWriteReq) begin
                m_tx_frame = {1'b1, uartWriteData, 1'b0};
                m_tx_left  = FRAME;
            end
            if (uartReadReq && m_q.size() > 0 && !m_ack) begin
                m_data = m_q.pop_front();
                m_ack  = 1'b1;
            end else begin
                m_ack = 1'b0;
            end
            if (pend.size() > 0 && pend[0].due == cyc) begin
                if (pend[0].stop) begin
                    if (m_q.size() < DEPTH) m_q.push_back(pend[0].data);
                    else m_ovr = 1'b1;
                end
                void'(pend.pop_front());
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (reset === 1'b1) begin
            check("tx", 32'(tx), 32'(m_tx_exp()));
            check("write_ready", 32'(uartWriteReady), 32'(m_tx_left == 0));
            check("read_ack", 32'(uartReadAck), 32'(m_ack));
            check("read_data", 32'(uartReadData), 32'(m_data));
            check("overrun", 32'(rxOverrun), 32'(m_ovr));
        end
    end

    // -----------------------------------------------------------------------
    // Stimulus helpers
    // -----------------------------------------------------------------------
    int last_t0 = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        logic [9:0] f;
        frame_t     fr;
        f = {stop, d, 1'b0};
        tick();
        last_t0 = cyc;
        fr.due  = cyc + RX_LAT;
        fr.data = d;
        fr.stop = stop;
        pend.push_back(fr);
        for (int i = 0; i < 10; i++) begin
            rx = f[0];
            f  = f >> 1;
            repeat (CPB) tick();
        end
        rx = 1'b1;
    endtask

    task automatic write_byte(input logic [7:0] d);
        uartWriteData = d;
        uartWriteReq  = 1'b1;
        tick();
        uartWriteReq  = 1'b0;
    endtask

    task automatic read_byte(output logic [7:0] d, output logic ok);
        ok = 1'b0;
        d  = '0;
        uartReadReq = 1'b1;
        for (int i = 0; i < 200 && !ok; i++) begin
            tick();
            if (uartReadAck) begin
                ok = 1'b1;
                d  = uartReadData;
            end
        end
        uartReadReq = 1'b0;
    endtask

    // Holds the request for n cycles and returns how many acks were seen.
    task automatic count_acks(input int n, output int acks);
        acks = 0;
        uartReadReq = 1'b1;
        for (int i = 0; i < n; i++) begin
            tick();
            if (uartReadAck) acks++;
        end
        uartReadReq = 1'b0;
    endtask

    // Captures the 10 frame bits (mid-bit) of a transmission that started
    // in the current cycle; returns them LSB first (bit 0 = start bit).
    task automatic capture_frame(output logic [9:0] bits, output logic ready_late);
        bits = '0;
        ready_late = 1'b0;
        for (int i = 0; i < FRAME; i++) begin
            if (i % CPB == CPB / 2) bits = {tx, bits[9:1]};
            if (i == FRAME - 1) ready_late = uartWriteReady;
            tick();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // -----------------------------------------------------------------------
    // Directed scenarios
    // -----------------------------------------------------------------------
    initial begin
        logic [7:0] d;
        logic       ok;
        logic [9:0] bits;
        logic       rdy;
        int         acks;
        int         ack_cyc;

        reset         = 1'b0;
        rx            = 1'b1;
        uartReadReq   = 1'b0;
        uartWriteReq  = 1'b0;
        uartWriteData = '0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx", 32'(tx), 32'(1));
        check("rst_ready", 32'(uartWriteReady), 32'(1));
        check("rst_ack", 32'(uartReadAck), 32'(0));
        check("rst_data", 32'(uartReadData), 32'(0));
        check("rst_ovr", 32'(rxOverrun), 32'(0));
        reset = 1'b1;
        repeat (3) tick();

        // Write 0xA5: start, 1,0,1,0,0,1,0,1, stop
        write_byte(8'hA5);
        check("a5_ready_drop", 32'(uartWriteReady), 32'(0));
        capture_frame(bits, rdy);
        check("a5_frame", 32'(bits), 32'(10'b1_1010_0101_0));
        check("a5_ready_cyc39", 32'(rdy), 32'(0));
        check("a5_ready_cyc40", 32'(uartWriteReady), 32'(1));
        repeat (4) tick();

        // Read 0x3C after it has arrived
        send_frame(8'h3C, 1'b1);
        repeat (6) tick();
        read_byte(d, ok);
        check("rd3c_ok", 32'(ok), 32'(1));
        check("rd3c_data", 32'(d), 32'(8'h3C));
        tick();
        check("rd3c_one_cycle", 32'(uartReadAck), 32'(0));
        count_acks(10, acks);
        check("rd3c_empty_after", 32'(acks), 32'(0));

        // Early request, then 0x81 arrives: ack RX_LAT+1 = 43 edges after t0
        uartReadReq = 1'b1;
        repeat (5) tick();
        acks = 0;
        ack_cyc = -1;
        fork
            send_frame(8'h81, 1'b1);
            begin
                for (int i = 0; i < RX_LAT + 20; i++) begin
                    tick();
                    if (uartReadAck) begin
                        acks++;
                        if (ack_cyc < 0) begin
                            ack_cyc = cyc;
                            d = uartReadData;
                        end
                        uartReadReq = 1'b0;
                    end
                end
            end
        join
        uartReadReq = 1'b0;
        check("early_ack_count", 32'(acks), 32'(1));
        check("early_latency", 32'(ack_cyc - last_t0), 32'(43));
        check("early_data", 32'(d), 32'(8'h81));

        // One-cycle glitch, then a frame with a low stop bit
        tick();
        rx = 1'b0;
        tick();
        rx = 1'b1;
        repeat (20) tick();
        send_frame(8'h55, 1'b0);
        repeat (5) tick();
        check("ferr_ovr", 32'(rxOverrun), 32'(0));
        count_acks(12, acks);
        check("err_no_bytes", 32'(acks), 32'(0));

        // Full FIFO with a pop on the very edge of the fifth push
        send_frame(8'hA1, 1'b1);
        send_frame(8'hA2, 1'b1);
        send_frame(8'hA3, 1'b1);
        send_frame(8'hA4, 1'b1);
        fork
            send_frame(8'hA5, 1'b1);
            begin
                repeat (RX_LAT) tick();
                uartReadReq = 1'b1;
                tick();
                check("fpp_ack", 32'(uartReadAck), 32'(1));
                check("fpp_data", 32'(uartReadData), 32'(8'hA1));
                uartReadReq = 1'b0;
            end
        join
        repeat (4) tick();
        check("fpp_no_ovr", 32'(rxOverrun), 32'(0));
        for (int i = 0; i < 4; i++) begin
            read_byte(d, ok);
            check("fpp_rd_ok", 32'(ok), 32'(1));
            check("fpp_rd_data", 32'(d), 32'(8'hA2 + i));
            tick();
        end

        // Simultaneous TX and RX, with an ignored write while busy
        fork
            begin
                write_byte(8'h5A);
                repeat (10) tick();
                write_byte(8'hFF);
            end
            send_frame(8'hC3, 1'b1);
        join
        repeat (10) tick();
        check("dup_ready", 32'(uartWriteReady), 32'(1));
        read_byte(d, ok);
        check("dup_rd_data", 32'(d), 32'(8'hC3));
        tick();

        // Overrun: five frames, no reads
        for (int v = 1; v <= 5; v++) send_frame(8'(v), 1'b1);
        repeat (4) tick();
        check("ovr_set", 32'(rxOverrun), 32'(1));
        for (int i = 1; i <= 4; i++) begin
            read_byte(d, ok);
            check("ovr_rd_data", 32'(d), 32'(i));
            tick();
        end
        count_acks(20, acks);
        check("ovr_fifth_no_ack", 32'(acks), 32'(0));
        check("ovr_sticky", 32'(rxOverrun), 32'(1));

        // Reset during the data bits of 0xFF
        write_byte(8'hFF);
        repeat (10) tick();
        #2 reset = 1'b0;
        #1;
        check("mid_rst_tx", 32'(tx), 32'(1));
        check("mid_rst_ready", 32'(uartWriteReady), 32'(1));
        check("mid_rst_ovr", 32'(rxOverrun), 32'(0));
        tick();
        reset = 1'b1;
        repeat (2) tick();
        write_byte(8'h00);
        check("w00_ready_drop", 32'(uartWriteReady), 32'(0));
        capture_frame(bits, rdy);
        check("w00_frame", 32'(bits), 32'(10'b1_0000_0000_0));
        check("w00_ready_end", 32'(uartWriteReady), 32'(1));
        repeat (5) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
